// File: rtl/monolith_pkg.sv
// Shared types and helpers for the Monolith sponge front-end over GF(2^31-1).
// Latency: n/a (package only; functions are combinational).
// Backpressure: n/a.
//
// Holds the default geometry, the field word/state types, the sponge FSM
// encoding, and scalar field helpers for later squeeze/duplex blocks.
package monolith_pkg;

    localparam int DEF_WORD_WIDTH  = 31;
    localparam int DEF_STATE_SIZE  = 16;
    localparam int DEF_RATE        = 8;
    localparam int DEF_DIGEST_SIZE = 8;

    localparam logic [30:0] P = 31'h7FFFFFFF;

    typedef logic [30:0]   word_t;
    typedef word_t [0:15]  state_t;

    typedef enum logic [2:0] {
        ST_ABSORB  = 3'd0,
        ST_PAD     = 3'd1,
        ST_LAUNCH  = 3'd2,
        ST_PERMUTE = 3'd3,
        ST_SQUEEZE = 3'd4
    } fsm_t;

    // The all-ones word is the second encoding of zero in this field.
    function automatic word_t canon(word_t w);
        return (w == P) ? '0 : w;
    endfunction

    // Operands must already be canonical (< p); one conditional subtract suffices.
    function automatic word_t mod_add(word_t a, word_t b);
        logic [31:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= {1'b0, P}) ? word_t'(s - {1'b0, P}) : word_t'(s);
    endfunction

endpackage

// File: rtl/monolith_mod_add.sv
// Combinational adder modulo p = 2^WIDTH-1.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; operands are expected to be canonical (< p).
//
// Ports: a, b -- canonical operands; sum -- (a + b) mod p.
module monolith_mod_add #(
    parameter int WIDTH = 31
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    localparam logic [WIDTH:0] P_EXT = {1'b0, {WIDTH{1'b1}}};

    logic [WIDTH:0] raw;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b};
        sum = (raw >= P_EXT) ? WIDTH'(raw - P_EXT) : WIDTH'(raw);
    end

endmodule

// File: rtl/monolith_sponge.sv
// Sponge front-end: absorbs RATE words per block, runs the external Monolith core, squeezes a digest.
// Latency: one cycle per accepted word, +1 pad cycle, +1 launch cycle, + core latency per block.
// Backpressure: in_ready low outside ABSORB; digest held until digest_ready.
//
// Ports: clk/reset (async, active-low); in_valid/in_ready/in_word/in_last message stream;
// perm_reset/perm_state_in/perm_state_out/perm_valid to the permutation core (word i at
// bits [i*WORD_WIDTH +: WORD_WIDTH]); digest/digest_valid/digest_ready result handshake.
// Optional macro MONOLITH_SPONGE_PERF_EN adds perm_count and busy_cycles counters.
module monolith_sponge
    import monolith_pkg::*;
#(
    parameter int WORD_WIDTH  = DEF_WORD_WIDTH,
    parameter int STATE_SIZE  = DEF_STATE_SIZE,
    parameter int RATE        = DEF_RATE,
    parameter int DIGEST_SIZE = DEF_DIGEST_SIZE
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WORD_WIDTH-1:0]            in_word,
    input  logic                             in_last,
    output logic                             perm_reset,
    output logic [STATE_SIZE*WORD_WIDTH-1:0] perm_state_in,
    input  logic [STATE_SIZE*WORD_WIDTH-1:0] perm_state_out,
    input  logic                             perm_valid,
    output logic [DIGEST_SIZE*WORD_WIDTH-1:0] digest,
    output logic                             digest_valid,
    input  logic                             digest_ready
`ifdef MONOLITH_SPONGE_PERF_EN
    ,
    output logic [31:0]                      perm_count,
    output logic [31:0]                      busy_cycles
`endif
);

    localparam int IDX_W = (RATE > 1) ? $clog2(RATE) : 1;
    localparam logic [WORD_WIDTH-1:0] P_W = {WORD_WIDTH{1'b1}};

    logic [WORD_WIDTH-1:0] state_q [STATE_SIZE];
    logic [WORD_WIDTH-1:0] state_d [STATE_SIZE];
    logic [IDX_W-1:0]      idx_q, idx_d;
    fsm_t                  fsm_q, fsm_d;
    logic                  pad_pending_q, pad_pending_d;
    logic                  final_q, final_d;

    logic [WORD_WIDTH-1:0] cur_word;
    logic [WORD_WIDTH-1:0] addend;
    logic [WORD_WIDTH-1:0] sum;

    // Only rate words are ever addressed by idx; capacity words are untouched.
    always_comb begin
        cur_word = '0;
        for (int i = 0; i < RATE; i++) begin
            if (idx_q == IDX_W'(i)) cur_word = state_q[i];
        end
    end

    // PAD adds the constant 1; otherwise the canonicalised message word.
    assign addend = (fsm_q == ST_PAD) ? WORD_WIDTH'(1)
                  : ((in_word == P_W) ? '0 : in_word);

    monolith_mod_add #(.WIDTH(WORD_WIDTH)) u_add (
        .a   (cur_word),
        .b   (addend),
        .sum (sum)
    );

    assign in_ready     = (fsm_q == ST_ABSORB);
    assign perm_reset   = (fsm_q != ST_PERMUTE);
    assign digest_valid = (fsm_q == ST_SQUEEZE);

    always_comb begin
        perm_state_in = '0;
        for (int i = 0; i < STATE_SIZE; i++) perm_state_in[i*WORD_WIDTH +: WORD_WIDTH] = state_q[i];
        digest = '0;
        for (int i = 0; i < DIGEST_SIZE; i++) digest[i*WORD_WIDTH +: WORD_WIDTH] = state_q[i];
    end

    always_comb begin
        for (int i = 0; i < STATE_SIZE; i++) state_d[i] = state_q[i];
        idx_d         = idx_q;
        fsm_d         = fsm_q;
        pad_pending_d = pad_pending_q;
        final_d       = final_q;
        case (fsm_q)
            ST_ABSORB: begin
                if (in_valid) begin
                    for (int i = 0; i < RATE; i++) begin
                        if (idx_q == IDX_W'(i)) state_d[i] = sum;
                    end
                    if (idx_q == IDX_W'(RATE-1)) begin
                        // Last word filling the block: the pad needs a block of its own.
                        pad_pending_d = in_last;
                        fsm_d         = ST_LAUNCH;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (in_last) fsm_d = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                for (int i = 0; i < RATE; i++) begin
                    if (idx_q == IDX_W'(i)) state_d[i] = sum;
                end
                idx_d         = idx_q + 1'b1;
                final_d       = 1'b1;
                pad_pending_d = 1'b0;
                fsm_d         = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                idx_d = '0;
                fsm_d = ST_PERMUTE;
            end
            ST_PERMUTE: begin
                if (perm_valid) begin
                    for (int i = 0; i < STATE_SIZE; i++)
                        state_d[i] = perm_state_out[i*WORD_WIDTH +: WORD_WIDTH];
                    if (pad_pending_q)  fsm_d = ST_PAD;
                    else if (final_q)   fsm_d = ST_SQUEEZE;
                    else                fsm_d = ST_ABSORB;
                end
            end
            ST_SQUEEZE: begin
                if (digest_ready) begin
                    for (int i = 0; i < STATE_SIZE; i++) state_d[i] = '0;
                    final_d = 1'b0;
                    fsm_d   = ST_ABSORB;
                end
            end
            default: fsm_d = ST_ABSORB;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STATE_SIZE; i++) state_q[i] <= '0;
            idx_q         <= '0;
            fsm_q         <= ST_ABSORB;
            pad_pending_q <= 1'b0;
            final_q       <= 1'b0;
        end else begin
            for (int i = 0; i < STATE_SIZE; i++) state_q[i] <= state_d[i];
            idx_q         <= idx_d;
            fsm_q         <= fsm_d;
            pad_pending_q <= pad_pending_d;
            final_q       <= final_d;
        end
    end

`ifdef MONOLITH_SPONGE_PERF_EN
    logic [31:0] perm_count_q, perm_count_d;
    logic [31:0] busy_cycles_q, busy_cycles_d;

    always_comb begin
        perm_count_d  = perm_count_q;
        busy_cycles_d = busy_cycles_q;
        if (fsm_q == ST_LAUNCH && perm_count_q != 32'hFFFF_FFFF) perm_count_d = perm_count_q + 32'd1;
        if (fsm_q == ST_PERMUTE) busy_cycles_d = busy_cycles_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perm_count_q  <= '0;
            busy_cycles_q <= '0;
        end else begin
            perm_count_q  <= perm_count_d;
            busy_cycles_q <= busy_cycles_d;
        end
    end

    assign perm_count  = perm_count_q;
    assign busy_cycles = busy_cycles_q;
`endif

endmodule

// File: tb/tb_monolith_sponge.sv
// Self-checking bench for monolith_sponge with a stubbed permutation core.
// Latency: n/a (testbench).
// Backpressure: exercises held in_valid and delayed digest_ready.
module tb_monolith_sponge;

    localparam int  WW = 31;
    localparam int  SS = 16;
    localparam int  RT = 8;
    localparam int  DS = 8;
    localparam longint P = 64'h7FFFFFFF;

    typedef logic [WW-1:0]    word_t;
    typedef logic [SS*WW-1:0] flat_t;
    typedef logic [DS*WW-1:0] dig_t;

    typedef struct packed {
        logic [31:0]        len;
        logic [31:0]        mode;
        logic [31:0]        hold;
        logic [31:0]        perms;
        logic [15:0][30:0]  msg;
        logic [30:0]        f0, f1, f2;
        logic [30:0]        l0, l1, l2;
    } vec_t;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  in_valid, in_ready, in_last;
    word_t in_word;
    logic  perm_reset, perm_valid;
    flat_t perm_state_in, perm_state_out;
    dig_t  digest;
    logic  digest_valid, digest_ready;
`ifdef MONOLITH_SPONGE_PERF_EN
    logic [31:0] perm_count, busy_cycles;
`endif

    always #5 clk = ~clk;

    monolith_sponge dut (
        .clk            (clk),
        .reset          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_word        (in_word),
        .in_last        (in_last),
        .perm_reset     (perm_reset),
        .perm_state_in  (perm_state_in),
        .perm_state_out (perm_state_out),
        .perm_valid     (perm_valid),
        .digest         (digest),
        .digest_valid   (digest_valid),
        .digest_ready   (digest_ready)
`ifdef MONOLITH_SPONGE_PERF_EN
        ,
        .perm_count     (perm_count),
        .busy_cycles    (busy_cycles)
`endif
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic timeout_fail(input string nm);
        total_cnt++;
        $display("FAIL %s: timed out waiting for the DUT", nm);
    endtask

    // Stub core: mode 0 mixes the input words, mode 1 returns all p-1.
    function automatic flat_t stub_f(flat_t x, int mode);
        flat_t  y;
        longint a, b;
        y = '0;
        for (int i = 0; i < SS; i++) begin
            if (mode == 1) begin
                y[i*WW +: WW] = 31'h7FFFFFFE;
            end else begin
                a = longint'(x[i*WW +: WW]);
                b = longint'(x[((i+3)%SS)*WW +: WW]);
                y[i*WW +: WW] = WW'((a*5 + b + longint'(i)*1000 + 17) % P);
            end
        end
        return y;
    endfunction

    int stub_mode = 0;
    int stub_cnt  = 0;
    int stub_lat  = 3;

    always @(posedge clk) begin
        if (perm_reset) begin
            perm_valid <= 1'b0;
            stub_cnt   <= 0;
            stub_lat   <= int'($urandom_range(0, 5));
        end else begin
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt == stub_lat) begin
                perm_valid     <= 1'b1;
                perm_state_out <= stub_f(perm_state_in, stub_mode);
            end
        end
    end

    // Record each core input at the start of its run and watch that it stays put.
    flat_t cap[$];
    int    hold_err = 0;
    logic  prev_pr = 1'b1;

    always @(negedge clk) begin
        if (!perm_reset && prev_pr) cap.push_back(perm_state_in);
        else if (!perm_reset && cap.size() > 0 && perm_state_in !== cap[cap.size()-1]) hold_err++;
        prev_pr = perm_reset;
    end

    // Reference sponge: pad with 1 then zeros, add each block mod p, apply the stub.
    flat_t exp_ins[$];
    dig_t  exp_dig;

    task automatic model(input word_t msg[$], input int mode);
        longint st[SS];
        longint pm[$];
        flat_t  f;
        exp_ins.delete();
        for (int j = 0; j < SS; j++) st[j] = 0;
        foreach (msg[k]) pm.push_back((longint'(msg[k]) == P) ? 64'd0 : longint'(msg[k]));
        pm.push_back(1);
        while (pm.size() % RT != 0) pm.push_back(0);
        for (int b = 0; b < pm.size() / RT; b++) begin
            for (int j = 0; j < RT; j++) st[j] = (st[j] + pm[b*RT + j]) % P;
            for (int j = 0; j < SS; j++) f[j*WW +: WW] = st[j][WW-1:0];
            exp_ins.push_back(f);
            f = stub_f(f, mode);
            for (int j = 0; j < SS; j++) st[j] = longint'(f[j*WW +: WW]);
        end
        for (int j = 0; j < DS; j++) exp_dig[j*WW +: WW] = st[j][WW-1:0];
    endtask

    task automatic send_words(input word_t msg[$]);
        int t;
        foreach (msg[k]) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_word  = msg[k];
            in_last  = (k == msg.size() - 1);
            t = 0;
            while (!in_ready && t < 2000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 2000) timeout_fail("in_ready_wait");
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    dig_t last_dut_dig;

    task automatic run_msg(input string nm, input word_t msg[$], input int mode, input int hold);
        int   t;
        int   stab_err;
        dig_t d0;
        stub_mode = mode;
        cap.delete();
        hold_err = 0;
        model(msg, mode);
        send_words(msg);
        t = 0;
        while (!digest_valid && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) begin
            timeout_fail({nm, "_digest_wait"});
        end else begin
            d0 = digest;
            last_dut_dig = digest;
            check({nm, "_in_ready_squeeze"}, 512'(in_ready), 512'(0));
            stab_err = 0;
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                if (digest !== d0 || !digest_valid || in_ready) stab_err++;
            end
            check({nm, "_squeeze_hold"}, 512'(stab_err), 512'(0));
            check({nm, "_digest"}, 512'(d0), 512'(exp_dig));
            check({nm, "_perm_count"}, 512'(cap.size()), 512'(exp_ins.size()));
            for (int i = 0; i < cap.size() && i < exp_ins.size(); i++)
                check($sformatf("%s_perm_in%0d", nm, i), 512'(cap[i]), 512'(exp_ins[i]));
            check({nm, "_perm_in_stable"}, 512'(hold_err), 512'(0));
            digest_ready = 1'b1;
            @(negedge clk);
            digest_ready = 1'b0;
            check({nm, "_post_valid"}, 512'(digest_valid), 512'(0));
            check({nm, "_post_ready"}, 512'(in_ready), 512'(1));
            check({nm, "_post_state"}, 512'(perm_state_in), 512'(0));
        end
    endtask

    vec_t tbl[6];

    task automatic set_vec(input int i, input int len, input int mode, input int hold, input int perms,
                           input word_t f0, input word_t f1, input word_t f2,
                           input word_t l0, input word_t l1, input word_t l2);
        tbl[i]       = '0;
        tbl[i].len   = len;
        tbl[i].mode  = mode;
        tbl[i].hold  = hold;
        tbl[i].perms = perms;
        tbl[i].f0 = f0; tbl[i].f1 = f1; tbl[i].f2 = f2;
        tbl[i].l0 = l0; tbl[i].l1 = l1; tbl[i].l2 = l2;
    endtask

    initial begin
        word_t m[$];
        flat_t first, last;
        dig_t  dig_ref;
        int    t;

        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_word = '0; digest_ready = 1'b0;
        perm_valid = 1'b0; perm_state_out = '0;

        // Hand-derived vectors; mode 1 makes multi-block expectations computable by hand.
        set_vec(0, 2, 0, 0, 1, 5, 7, 1, 5, 7, 1);
        tbl[0].msg[0] = 5; tbl[0].msg[1] = 7;
        set_vec(1, 1, 0, 2, 1, 0, 1, 0, 0, 1, 0);
        tbl[1].msg[0] = 31'h7FFFFFFF;
        set_vec(2, 8, 1, 10, 2, 1, 2, 3, 0, 31'h7FFFFFFE, 31'h7FFFFFFE);
        for (int k = 0; k < 8; k++) tbl[2].msg[k] = 31'(k + 1);
        set_vec(3, 9, 1, 0, 2, 1, 2, 3, 2, 0, 31'h7FFFFFFE);
        for (int k = 0; k < 8; k++) tbl[3].msg[k] = 31'(k + 1);
        tbl[3].msg[8] = 3;
        set_vec(4, 2, 0, 1, 1, 31'h7FFFFFFE, 31'h7FFFFFFE, 1, 31'h7FFFFFFE, 31'h7FFFFFFE, 1);
        tbl[4].msg[0] = 31'h7FFFFFFE; tbl[4].msg[1] = 31'h7FFFFFFE;
        set_vec(5, 16, 1, 0, 3, 10, 11, 12, 0, 31'h7FFFFFFE, 31'h7FFFFFFE);
        for (int k = 0; k < 16; k++) tbl[5].msg[k] = 31'(k + 10);

        repeat (2) @(negedge clk);
        #1;
        check("rst_perm_reset", 512'(perm_reset), 512'(1));
        check("rst_in_ready", 512'(in_ready), 512'(1));
        check("rst_digest_valid", 512'(digest_valid), 512'(0));
        check("rst_digest", 512'(digest), 512'(0));
        check("rst_perm_state_in", 512'(perm_state_in), 512'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            m.delete();
            for (int k = 0; k < int'(tbl[i].len); k++) m.push_back(tbl[i].msg[k]);
            run_msg($sformatf("vec%0d", i), m, int'(tbl[i].mode), int'(tbl[i].hold));
            if (i == 0) dig_ref = last_dut_dig;
            first = (cap.size() > 0) ? cap[0] : '0;
            last  = (cap.size() > 0) ? cap[cap.size()-1] : '0;
            check($sformatf("vec%0d_nperm", i), 512'(cap.size()), 512'(tbl[i].perms));
            check($sformatf("vec%0d_first_w0", i), 512'(first[0 +: WW]), 512'(tbl[i].f0));
            check($sformatf("vec%0d_first_w1", i), 512'(first[WW +: WW]), 512'(tbl[i].f1));
            check($sformatf("vec%0d_first_w2", i), 512'(first[2*WW +: WW]), 512'(tbl[i].f2));
            check($sformatf("vec%0d_last_w0", i), 512'(last[0 +: WW]), 512'(tbl[i].l0));
            check($sformatf("vec%0d_last_w1", i), 512'(last[WW +: WW]), 512'(tbl[i].l1));
            check($sformatf("vec%0d_last_w2", i), 512'(last[2*WW +: WW]), 512'(tbl[i].l2));
        end

        // Reset while the core is running aborts straight to the idle outputs.
        stub_mode = 0;
        m.delete(); m.push_back(5); m.push_back(7);
        send_words(m);
        t = 0;
        while (perm_reset && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) timeout_fail("abort_permute_wait");
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_perm_reset", 512'(perm_reset), 512'(1));
        check("abort_digest_valid", 512'(digest_valid), 512'(0));
        check("abort_in_ready", 512'(in_ready), 512'(1));
        check("abort_state", 512'(perm_state_in), 512'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_msg("after_abort", m, 0, 0);
        check("after_abort_same_digest", 512'(last_dut_dig), 512'(dig_ref));

        // Randomised messages, sprinkled with p and p-1 words.
        for (int r = 0; r < 8; r++) begin
            int len;
            int sel;
            len = int'($urandom_range(1, 20));
            m.delete();
            for (int k = 0; k < len; k++) begin
                sel = int'($urandom_range(0, 9));
                if (sel == 0)      m.push_back(31'h7FFFFFFF);
                else if (sel == 1) m.push_back(31'h7FFFFFFE);
                else               m.push_back(31'($urandom));
            end
            run_msg($sformatf("rand%0d", r), m, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
